alu_regfile_flags: RTL and testbench

Operand/result register stage wrapped around the 8-bit ALU. Holds a small general-purpose register file whose two combinational read ports drive ALU operands A and B. The write port captures ALU result y, and a status register captures the ALU flags z/n/c/v/bor under a per-flag write mask. The latched carry is fed back to the ALU as Ext_cin so that multi-byte add/subtract chains work across consecutive cycles.

---
 rtl/alu_regfile_flags.sv | 48 ++++
 tb/tb_alu_regfile_flags.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_flags.sv
// alu_regfile_flags: register file, masked flag register and carry feedback around the 8-bit ALU.
module alu_regfile_flags #(
  parameter int DW = 8,
  parameter int NREGS = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] y,
  input  logic          z,
  input  logic          n,
  input  logic          c,
  input  logic          v,
  input  logic          bor,
  input  logic [4:0]    flag_we,
  input  logic          use_carry,
  input  logic          stall,
  output logic          Ext_cin,
  output logic [4:0]    flags,
  output logic [7:0]    wr_count
);
  logic [DW-1:0] regs [NREGS];
  logic          commit;
  assign commit = wr_en & ~stall & ~rst;
  // write-first bypass so a chained op sees the result being written this cycle
  assign A = (commit && wr_addr == ra_addr) ? y : regs[ra_addr];
  assign B = (commit && wr_addr == rb_addr) ? y : regs[rb_addr];
  assign Ext_cin = use_carry & flags[2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags <= '0;
      wr_count <= '0;
    end else begin
      if (commit) begin
        regs[wr_addr] <= y;
        wr_count <= wr_count + 8'd1;
      end
      if (!stall) flags <= (flags & ~flag_we) | ({z, n, c, v, bor} & flag_we);
    end
  end
endmodule

// File: tb/tb_alu_regfile_flags.sv
// tb_alu_regfile_flags: directed tests for the ALU register/flag stage.
module tb_alu_regfile_flags;
  logic       clk = 0;
  logic       rst = 1;
  logic [1:0] ra_addr = 0, rb_addr = 0, wr_addr = 0;
  logic [7:0] A, B, y = 0;
  logic       wr_en = 0, z = 0, n = 0, c = 0, v = 0, bor = 0, use_carry = 0, stall = 0;
  logic [4:0] flag_we = 0;
  logic       Ext_cin;
  logic [4:0] flags;
  logic [7:0] wr_count;
  int checks = 0;
  int errors = 0;

  alu_regfile_flags dut (
    .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr), .A(A), .B(B),
    .wr_en(wr_en), .wr_addr(wr_addr), .y(y), .z(z), .n(n), .c(c), .v(v), .bor(bor),
    .flag_we(flag_we), .use_carry(use_carry), .stall(stall), .Ext_cin(Ext_cin),
    .flags(flags), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (A !== 8'h00) begin errors++; $display("FAIL reset_A got %h exp 00", A); end
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags got %b exp 00000", flags); end
    checks++; if (wr_count !== 8'h00) begin errors++; $display("FAIL reset_count got %h exp 00", wr_count); end
    tick();
    rst = 0;
    wr_en = 1; wr_addr = 1; y = 8'h55;
    tick();
    wr_en = 0; ra_addr = 1;
    #1;
    checks++; if (A !== 8'h55) begin errors++; $display("FAIL r1_written got %h exp 55", A); end
    checks++; if (wr_count !== 8'h01) begin errors++; $display("FAIL r1_count got %h exp 01", wr_count); end
    use_carry = 1;
    rst = 1; wr_en = 1; y = 8'h77;
    #1;
    checks++; if (A !== 8'h00) begin errors++; $display("FAIL async_reset_A got %h exp 00", A); end
    checks++; if (wr_count !== 8'h00) begin errors++; $display("FAIL async_reset_count got %h exp 00", wr_count); end
    checks++; if (Ext_cin !== 1'b0) begin errors++; $display("FAIL async_reset_cin got %b exp 0", Ext_cin); end
    tick();
    checks++; if (A !== 8'h00) begin errors++; $display("FAIL reset_overrides_write got %h exp 00", A); end
    rst = 0; wr_en = 0; use_carry = 0;
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 2; y = 8'h0F; ra_addr = 2; rb_addr = 2;
    #1;
    checks++; if (A !== 8'h0F) begin errors++; $display("FAIL bypass_A got %h exp 0f", A); end
    checks++; if (B !== 8'h0F) begin errors++; $display("FAIL bypass_B got %h exp 0f", B); end
    tick();
    wr_en = 0; y = 8'h00;
    #1;
    checks++; if (A !== 8'h0F) begin errors++; $display("FAIL stored_A got %h exp 0f", A); end
    checks++; if (wr_count !== 8'h01) begin errors++; $display("FAIL bypass_count got %h exp 01", wr_count); end
  endtask

  task automatic test_flag_mask();
    c = 1; z = 1; flag_we = 5'b00100;
    tick();
    checks++; if (flags !== 5'b00100) begin errors++; $display("FAIL mask_c got %b exp 00100", flags); end
    z = 1; c = 0; flag_we = 5'b10000;
    tick();
    checks++; if (flags !== 5'b10100) begin errors++; $display("FAIL mask_z got %b exp 10100", flags); end
    checks++; if (wr_count !== 8'h01) begin errors++; $display("FAIL flags_no_write got %h exp 01", wr_count); end
    z = 0; flag_we = 5'b00000;
  endtask

  task automatic test_carry_chain();
    flag_we = 5'b11111;
    tick();
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL flags_clear got %b exp 00000", flags); end
    use_carry = 1; c = 1; flag_we = 5'b00100;
    #1;
    checks++; if (Ext_cin !== 1'b0) begin errors++; $display("FAIL cin_not_bypassed got %b exp 0", Ext_cin); end
    tick();
    c = 0; flag_we = 5'b00000;
    #1;
    checks++; if (Ext_cin !== 1'b1) begin errors++; $display("FAIL cin_chain got %b exp 1", Ext_cin); end
    use_carry = 0;
    #1;
    checks++; if (Ext_cin !== 1'b0) begin errors++; $display("FAIL cin_off got %b exp 0", Ext_cin); end
  endtask

  task automatic test_stall();
    wr_en = 1; wr_addr = 3; y = 8'h33;
    tick();
    stall = 1; y = 8'hAA; flag_we = 5'b11111;
    z = 1; n = 1; c = 1; v = 1; bor = 1; rb_addr = 3;
    #1;
    checks++; if (B !== 8'h33) begin errors++; $display("FAIL stall_no_bypass got %h exp 33", B); end
    tick();
    checks++; if (B !== 8'h33) begin errors++; $display("FAIL stall_reg got %h exp 33", B); end
    checks++; if (flags !== 5'b00100) begin errors++; $display("FAIL stall_flags got %b exp 00100", flags); end
    checks++; if (wr_count !== 8'h02) begin errors++; $display("FAIL stall_count got %h exp 02", wr_count); end
    stall = 0; wr_en = 0; flag_we = 5'b00000;
    z = 0; n = 0; c = 0; v = 0; bor = 0;
  endtask

  task automatic test_back_to_back();
    wr_en = 1; wr_addr = 0; y = 8'h11;
    tick();
    wr_addr = 1; y = 8'h22;
    tick();
    wr_addr = 2; y = 8'h44;
    tick();
    wr_en = 0; ra_addr = 0; rb_addr = 1;
    #1;
    checks++; if (A !== 8'h11) begin errors++; $display("FAIL b2b_r0 got %h exp 11", A); end
    checks++; if (B !== 8'h22) begin errors++; $display("FAIL b2b_r1 got %h exp 22", B); end
    ra_addr = 2; rb_addr = 3;
    #1;
    checks++; if (A !== 8'h44) begin errors++; $display("FAIL b2b_r2 got %h exp 44", A); end
    checks++; if (B !== 8'h33) begin errors++; $display("FAIL b2b_r3 got %h exp 33", B); end
    wr_en = 1; wr_addr = 0; y = 8'h99; ra_addr = 0; rb_addr = 1;
    #1;
    checks++; if (A !== 8'h99) begin errors++; $display("FAIL b2b_bypass_A got %h exp 99", A); end
    checks++; if (B !== 8'h22) begin errors++; $display("FAIL b2b_other_B got %h exp 22", B); end
    tick();
    wr_en = 0;
    #1;
    checks++; if (wr_count !== 8'h06) begin errors++; $display("FAIL b2b_count got %h exp 06", wr_count); end
  endtask

  task automatic test_wrap();
    rst = 1;
    #1;
    rst = 0;
    for (int i = 0; i < 255; i++) begin
      wr_en = 1; wr_addr = 2'(i); y = 8'(i);
      tick();
    end
    wr_en = 0; ra_addr = 2; rb_addr = 1;
    #1;
    checks++; if (wr_count !== 8'hFF) begin errors++; $display("FAIL count_255 got %h exp ff", wr_count); end
    checks++; if (A !== 8'hFE) begin errors++; $display("FAIL wrap_r2 got %h exp fe", A); end
    checks++; if (B !== 8'hFD) begin errors++; $display("FAIL wrap_r1 got %h exp fd", B); end
    wr_en = 1; wr_addr = 3; y = 8'hFF;
    tick();
    wr_en = 0;
    #1;
    checks++; if (wr_count !== 8'h00) begin errors++; $display("FAIL count_wrap got %h exp 00", wr_count); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_flag_mask();
    test_carry_chain();
    test_stall();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
